// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with a valid/ready handshake on both sides.
// Single-cycle ops complete at the accepting edge. mul (shift-add) and
// divu/remu (restoring division) take WIDTH iterations in BUSY.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  logic [1:0]       state_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;    // multiplicand (shifts left) or dividend/quotient
  logic [WIDTH-1:0] b_r;    // multiplier (shifts right) or divisor
  logic [WIDTH-1:0] acc_r;  // partial product or partial remainder
  logic [SHW:0]     cnt_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             overflow_r;
  logic             illegal_r;
  logic             out_valid_r;

  logic             sub_s;
  logic [WIDTH-1:0] b_inv_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovf_s;
  logic             alu_ill_s;
  logic             is_multi_s;
  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH:0]   div_trial_s;
  logic             div_ok_s;
  logic [WIDTH-1:0] div_rem_s;
  logic [WIDTH-1:0] div_quo_s;
  logic [WIDTH-1:0] iter_res_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;
  assign overflow  = overflow_r;
  assign illegal   = illegal_r;

  // Shared adder: slt uses the subtract path so its sign/overflow are reused.
  always_comb begin
    sub_s   = (alucontrol == OP_SUB) || (alucontrol == OP_SLT);
    b_inv_s = sub_s ? ~b : b;
    sum_s   = a + b_inv_s + {{(WIDTH-1){1'b0}}, sub_s};
    ovf_s   = (a[WIDTH-1] == b_inv_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
    shamt_s = b[SHW-1:0];
  end

  // Single-cycle result, overflow and illegal-op decode.
  always_comb begin
    alu_res_s  = {WIDTH{1'b0}};
    alu_ovf_s  = 1'b0;
    alu_ill_s  = 1'b0;
    is_multi_s = 1'b0;
    case (alucontrol)
      OP_ADD, OP_SUB: begin
        alu_res_s = sum_s;
        alu_ovf_s = ovf_s;
      end
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_XOR:  alu_res_s = a ^ b;
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_s};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res_s = a << shamt_s;
      OP_SRL:  alu_res_s = a >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(a) >>> shamt_s);
      OP_MUL, OP_DIVU, OP_REMU: is_multi_s = 1'b1;
      default: alu_ill_s = 1'b1;
    endcase
  end

  // One iteration of shift-add multiply and of restoring division.
  // A zero divisor always "fits", giving an all-ones quotient and remainder = a.
  always_comb begin
    mul_acc_s   = acc_r + (b_r[0] ? a_r : {WIDTH{1'b0}});
    div_trial_s = {acc_r, a_r[WIDTH-1]} - {1'b0, b_r};
    div_ok_s    = ~div_trial_s[WIDTH];
    div_rem_s   = div_ok_s ? div_trial_s[WIDTH-1:0] : {acc_r[WIDTH-2:0], a_r[WIDTH-1]};
    div_quo_s   = {a_r[WIDTH-2:0], div_ok_s};
    case (op_r)
      OP_MUL:  iter_res_s = mul_acc_s;
      OP_DIVU: iter_res_s = div_quo_s;
      OP_REMU: iter_res_s = div_rem_s;
      default: iter_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      op_r        <= 4'd0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      cnt_r       <= {(SHW+1){1'b0}};
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
      illegal_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            if (is_multi_s) begin
              op_r    <= alucontrol;
              a_r     <= a;
              b_r     <= b;
              acc_r   <= {WIDTH{1'b0}};
              cnt_r   <= CNT_INIT;
              state_r <= BUSY;
            end else begin
              result_r    <= alu_res_s;
              zero_r      <= (alu_res_s == {WIDTH{1'b0}});
              overflow_r  <= alu_ovf_s;
              illegal_r   <= alu_ill_s;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end
          end
        end
        BUSY: begin
          cnt_r <= cnt_r - CNT_ONE;
          if (op_r == OP_MUL) begin
            acc_r <= mul_acc_s;
            a_r   <= {a_r[WIDTH-2:0], 1'b0};
            b_r   <= {1'b0, b_r[WIDTH-1:1]};
          end else begin
            acc_r <= div_rem_s;
            a_r   <= div_quo_s;
          end
          if (cnt_r == CNT_ONE) begin
            result_r    <= iter_res_s;
            zero_r      <= (iter_res_s == {WIDTH{1'b0}});
            overflow_r  <= 1'b0;
            illegal_r   <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed table-driven bench for alu_mc at WIDTH=32 and WIDTH=8,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // WIDTH=32 instance
  logic        iv32, ir32, ov32, or32, z32, o32, il32;
  logic [31:0] a32, b32, r32;
  logic [3:0]  op32;
  // WIDTH=8 instance
  logic        iv8, ir8, ov8, or8, z8, o8, il8;
  logic [7:0]  a8, b8, r8;
  logic [3:0]  op8;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .alucontrol(op32), .out_valid(ov32), .out_ready(or32),
    .result(r32), .zero(z32), .overflow(o32), .illegal(il32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .alucontrol(op8), .out_valid(ov8), .out_ready(or8),
    .result(r8), .zero(z8), .overflow(o8), .illegal(il8)
  );

  // lat = posedges counted from the accepting edge (inclusive) until out_valid
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
    int          lat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  vec_t v32 [0:21];
  vec_t v8  [0:5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    if (sel == 32) begin
      iv32 = v; op32 = op; a32 = a; b32 = b;
    end else begin
      iv8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  task automatic set_ordy(input int sel, input logic v);
    if (sel == 32) or32 = v;
    else or8 = v;
  endtask

  function automatic logic get_ov(input int sel);
    return (sel == 32) ? ov32 : ov8;
  endfunction

  function automatic logic get_ir(input int sel);
    return (sel == 32) ? ir32 : ir8;
  endfunction

  function automatic logic [31:0] get_res(input int sel);
    return (sel == 32) ? r32 : {24'h0, r8};
  endfunction

  function automatic logic [2:0] get_flags(input int sel);
    return (sel == 32) ? {z32, o32, il32} : {z8, o8, il8};
  endfunction

  // Issue one op, wait (bounded) for out_valid, compare, then consume it.
  task automatic run_op(input int sel, input vec_t v, input string name);
    int   edges;
    logic rdy_seen;
    chk({name, ".in_ready_idle"}, {31'h0, get_ir(sel)}, 32'h1);
    set_in(sel, 1'b1, v.op, v.a, v.b);
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after accept: must have no effect.
    set_in(sel, 1'b0, ~v.op, ~v.a, ~v.b);
    edges    = 1;
    rdy_seen = 1'b0;
    while (!get_ov(sel) && edges < 100) begin
      if (get_ir(sel)) rdy_seen = 1'b1;
      @(negedge clk);
      edges++;
    end
    chk({name, ".latency"}, edges, v.lat);
    chk({name, ".result"}, get_res(sel), v.res);
    chk({name, ".zero/ovf/ill"}, {29'h0, get_flags(sel)}, {29'h0, v.z, v.o, v.il});
    if (v.lat > 1) chk({name, ".in_ready_busy"}, {31'h0, rdy_seen}, 32'h0);
    chk({name, ".in_ready_done"}, {31'h0, get_ir(sel)}, 32'h0);
    set_ordy(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(sel, 1'b0);
    chk({name, ".out_valid_cleared"}, {31'h0, get_ov(sel)}, 32'h0);
  endtask

  initial begin
    vec_t vt;
    logic seen;
    int   n;

    //          op     a             b             res           z     o     il    lat
    v32[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1};
    v32[1]  = '{4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    v32[2]  = '{4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1};
    v32[3]  = '{4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1};
    v32[4]  = '{4'h3, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0, 1'b0, 1'b0, 1};
    v32[5]  = '{4'h4, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0, 1'b0, 1};
    v32[6]  = '{4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    v32[7]  = '{4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    v32[8]  = '{4'h9, 32'h80000000, 32'd36,       32'hF8000000, 1'b0, 1'b0, 1'b0, 1};
    v32[9]  = '{4'h8, 32'h80000000, 32'd36,       32'h08000000, 1'b0, 1'b0, 1'b0, 1};
    v32[10] = '{4'h7, 32'h00000001, 32'd31,       32'h80000000, 1'b0, 1'b0, 1'b0, 1};
    v32[11] = '{4'h7, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 1'b0, 1};
    v32[12] = '{4'hE, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1};
    v32[13] = '{4'hD, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1};
    v32[14] = '{4'hA, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 1'b0, 1'b0, 33};
    v32[15] = '{4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 33};
    v32[16] = '{4'hB, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b0, 33};
    v32[17] = '{4'hC, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 1'b0, 33};
    v32[18] = '{4'hB, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33};
    v32[19] = '{4'hC, 32'd9,        32'd0,        32'd9,        1'b0, 1'b0, 1'b0, 33};
    v32[20] = '{4'hC, 32'd7,        32'd7,        32'd0,        1'b1, 1'b0, 1'b0, 33};
    v32[21] = '{4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1, 1};

    v8[0]   = '{4'h0, 32'h7F,       32'h01,       32'h80,       1'b0, 1'b1, 1'b0, 1};
    v8[1]   = '{4'hA, 32'hFF,       32'hFF,       32'h01,       1'b0, 1'b0, 1'b0, 9};
    v8[2]   = '{4'hB, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b0, 9};
    v8[3]   = '{4'hC, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 1'b0, 9};
    v8[4]   = '{4'hB, 32'd9,        32'd0,        32'hFF,       1'b0, 1'b0, 1'b0, 9};
    v8[5]   = '{4'h9, 32'h80,       32'd3,        32'hF0,       1'b0, 1'b0, 1'b0, 1};

    set_in(32, 1'b0, 4'h0, 32'h0, 32'h0);
    set_in(8,  1'b0, 4'h0, 32'h0, 32'h0);
    or32  = 1'b0;
    or8   = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset state
    chk("rst.out_valid", {31'h0, ov32}, 32'h0);
    chk("rst.result", r32, 32'h0);
    chk("rst.flags", {29'h0, z32, o32, il32}, 32'h0);
    chk("rst.in_ready", {31'h0, ir32}, 32'h1);
    chk("rst8.result_valid", {23'h0, ov8, r8}, 32'h0);

    for (int i = 0; i <= 21; i++) run_op(32, v32[i], $sformatf("w32[%0d]", i));
    for (int i = 0; i <= 5; i++)  run_op(8,  v8[i],  $sformatf("w8[%0d]", i));

    // Backpressure: add 3+4 held for 5 cycles while a second request waits.
    set_in(32, 1'b1, 4'h0, 32'd3, 32'd4);
    @(posedge clk);
    @(negedge clk);
    set_in(32, 1'b1, 4'h1, 32'd10, 32'd4);
    chk("bp.first_valid", {31'h0, ov32}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp.hold%0d", k), {ov32, ir32, z32, o32, il32, 27'h0} | {27'h0, r32[4:0]},
          {5'b10000, 27'h0} | 32'd7);
    end
    or32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or32 = 1'b0;
    chk("bp.no_same_cycle_accept", {30'h0, ov32, ir32}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    set_in(32, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("bp.second_result", {31'h0, ov32}, 32'h1);
    chk("bp.second_value", r32, 32'd6);
    or32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or32 = 1'b0;

    // Reset during BUSY cycle 10 of a divu discards the operation.
    set_in(32, 1'b1, 4'hB, 32'd100, 32'd7);
    @(posedge clk);
    @(negedge clk);
    set_in(32, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    chk("rstbusy.pre_busy", {31'h0, ir32}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rstbusy.out_valid", {31'h0, ov32}, 32'h0);
    chk("rstbusy.result", r32, 32'h0);
    chk("rstbusy.in_ready", {31'h0, ir32}, 32'h1);
    seen = 1'b0;
    n = 0;
    while (n < 40) begin
      if (ov32) seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("rstbusy.no_stale_valid", {31'h0, seen}, 32'h0);
    vt = '{4'h0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0, 1};
    run_op(32, vt, "rstbusy.add");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
